// File: rtl/de1_soc_st_packet_arbiter.sv
// rtl/de1_soc_st_packet_arbiter.sv - round-robin Avalon-ST packet arbiter with registered output stage
// Optional stall watchdog: define ST_ARB_WATCHDOG_EN
module de1_soc_st_packet_arbiter #(
  parameter int NUM_INPUTS     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_INPUTS-1:0]   in_valid,
  output logic [NUM_INPUTS-1:0]   in_ready,
  input  logic [8*NUM_INPUTS-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]   in_startofpacket,
  input  logic [NUM_INPUTS-1:0]   in_endofpacket,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_data,
  output logic [7:0]              out_channel,
  output logic                    out_startofpacket,
  output logic                    out_endofpacket,
  output logic [NUM_INPUTS-1:0]   grant,
  output logic                    timeout_err
);

  localparam int IDX_W = $clog2(NUM_INPUTS);

  typedef enum logic {IDLE, PACKET} state_t;

  state_t                state_q, state_d;
  logic [NUM_INPUTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]      cur_q, cur_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic                  out_valid_q, out_valid_d;
  logic [7:0]            out_data_q, out_data_d;
  logic [7:0]            out_channel_q, out_channel_d;
  logic                  out_sop_q, out_sop_d;
  logic                  out_eop_q, out_eop_d;

  logic [IDX_W-1:0]      cand;
  logic [IDX_W-1:0]      pick;
  logic                  found;
  logic                  accept;

`ifdef ST_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic                  timeout_err_q, timeout_err_d;
`else
  logic                  unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // Only the granted source sees ready, and only when the output register can take a beat
  assign in_ready = (!reset && state_q == PACKET && (!out_valid_q || out_ready)) ? grant_q : '0;
  assign accept   = |(in_valid & in_ready);

  // Round-robin search starting just after the source that finished last
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    cand  = '0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      cand = IDX_W'((int'(last_q) + k) % NUM_INPUTS);
      if (!found && in_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next-state: output register load/drain plus IDLE/PACKET sequencing
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    cur_d         = cur_q;
    last_d        = last_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    out_sop_d     = out_sop_q;
    out_eop_d     = out_eop_q;
`ifdef ST_ARB_WATCHDOG_EN
    stall_cnt_d   = stall_cnt_q;
    timeout_err_d = timeout_err_q;
`endif

    if (accept) begin
      out_valid_d   = 1'b1;
      out_data_d    = in_data[{cur_q, 3'b000} +: 8];
      out_channel_d = 8'(cur_q);
      out_sop_d     = in_startofpacket[cur_q];
      out_eop_d     = in_endofpacket[cur_q];
    end else if (out_ready) begin
      out_valid_d   = 1'b0;
    end

    case (state_q)
      IDLE: begin
`ifdef ST_ARB_WATCHDOG_EN
        stall_cnt_d = '0;
`endif
        if (found) begin
          state_d = PACKET;
          cur_d   = pick;
          grant_d = NUM_INPUTS'(1) << pick;
        end
      end
      PACKET: begin
        if (accept) begin
`ifdef ST_ARB_WATCHDOG_EN
          stall_cnt_d = '0;
`endif
          if (in_endofpacket[cur_q]) begin
            state_d = IDLE;
            grant_d = '0;
            last_d  = cur_q;
          end
        end
`ifdef ST_ARB_WATCHDOG_EN
        else if (!in_valid[cur_q]) begin
          // Source went silent mid-packet: give up on it after the stall limit
          if (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d       = IDLE;
            grant_d       = '0;
            last_d        = cur_q;
            timeout_err_d = 1'b1;
            stall_cnt_d   = '0;
          end else begin
            stall_cnt_d   = stall_cnt_q + 1'b1;
          end
        end
`endif
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      cur_q         <= '0;
      last_q        <= IDX_W'(NUM_INPUTS - 1);
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
`ifdef ST_ARB_WATCHDOG_EN
      stall_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      cur_q         <= cur_d;
      last_q        <= last_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
`ifdef ST_ARB_WATCHDOG_EN
      stall_cnt_q   <= stall_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign grant             = grant_q;
  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign out_channel       = out_channel_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;
`ifdef ST_ARB_WATCHDOG_EN
  assign timeout_err       = timeout_err_q;
`else
  assign timeout_err       = 1'b0;
`endif

endmodule

// File: tb/tb_de1_soc_st_packet_arbiter.sv
// tb/tb_de1_soc_st_packet_arbiter.sv - randomized self-checking bench for de1_soc_st_packet_arbiter
`timescale 1ns/1ps
module tb_de1_soc_st_packet_arbiter;

  localparam int NI = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NI-1:0]   in_valid = '0;
  logic [NI-1:0]   in_ready;
  logic [8*NI-1:0] in_data = '0;
  logic [NI-1:0]   in_startofpacket = '0;
  logic [NI-1:0]   in_endofpacket = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [7:0]      out_data;
  logic [7:0]      out_channel;
  logic            out_startofpacket;
  logic            out_endofpacket;
  logic [NI-1:0]   grant;
  logic            timeout_err;

  de1_soc_st_packet_arbiter #(.NUM_INPUTS(NI), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_channel(out_channel), .out_startofpacket(out_startofpacket),
    .out_endofpacket(out_endofpacket), .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Per-source packet queues, beat = {eop, sop, data}
  logic [9:0] src_q [NI][$];
  bit         hold [NI];
  int         prob [NI];

  // Reference model: which source owns the output, who finished last, output register contents
  bit         m_pkt  = 1'b0;
  int         m_g    = 0;
  int         m_last = NI - 1;
  int         m_cnt  = 0;
  bit         m_ov   = 1'b0;
  logic [7:0] m_od   = '0;
  logic [7:0] m_oc   = '0;
  bit         m_os   = 1'b0;
  bit         m_oe   = 1'b0;
  bit         m_err  = 1'b0;

  // Beats observed leaving the DUT
  int         log_cyc[$];
  logic [7:0] log_ch[$];
  logic [7:0] log_d[$];
  logic       log_sop[$];
  logic       log_eop[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [9:0] bt(input bit eop, input bit sop, input logic [7:0] d);
    return {eop, sop, d};
  endfunction

  task automatic drive();
    logic [9:0] b;
    for (int i = 0; i < NI; i++) begin
      b = (src_q[i].size() > 0) ? src_q[i][0] : 10'($urandom);
      in_valid[i] = (src_q[i].size() > 0) && !hold[i] && ($urandom_range(99) < prob[i]);
      in_data[8*i +: 8]   = b[7:0];
      in_startofpacket[i] = b[8];
      in_endofpacket[i]   = b[9];
    end
  endtask

  task automatic compare();
    logic [NI-1:0] exp_gnt;
    logic [NI-1:0] exp_rdy;
    exp_gnt = m_pkt ? (NI'(1) << m_g) : '0;
    exp_rdy = (!reset && m_pkt && (!m_ov || out_ready)) ? exp_gnt : '0;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("grant", 32'(grant), 32'(exp_gnt));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_data", 32'(out_data), 32'(m_od));
    check("out_channel", 32'(out_channel), 32'(m_oc));
    check("out_sop", 32'(out_startofpacket), 32'(m_os));
    check("out_eop", 32'(out_endofpacket), 32'(m_oe));
    check("timeout_err", 32'(timeout_err), 32'(m_err));
    if (!reset && out_valid && out_ready) begin
      log_cyc.push_back(cyc);
      log_ch.push_back(out_channel);
      log_d.push_back(out_data);
      log_sop.push_back(out_startofpacket);
      log_eop.push_back(out_endofpacket);
    end
  endtask

  // Advance the model across one rising edge using the inputs currently applied
  task automatic model_step();
    bit         acc;
    bit         found;
    int         s;
    logic [9:0] b;
    if (reset) begin
      m_pkt = 0; m_g = 0; m_last = NI - 1; m_cnt = 0;
      m_ov = 0; m_od = '0; m_oc = '0; m_os = 0; m_oe = 0; m_err = 0;
      return;
    end
    acc = m_pkt && (!m_ov || out_ready) && in_valid[m_g];
    if (acc) begin
      b = src_q[m_g].pop_front();
      m_ov = 1; m_od = b[7:0]; m_oc = 8'(m_g); m_os = b[8]; m_oe = b[9];
      m_cnt = 0;
      if (b[9]) begin
        m_pkt  = 0;
        m_last = m_g;
      end
    end else begin
      if (out_ready) m_ov = 0;
      if (!m_pkt) begin
        m_cnt = 0;
        found = 0;
        for (int k = 1; k <= NI; k++) begin
          s = (m_last + k) % NI;
          if (!found && in_valid[s]) begin
            found = 1; m_pkt = 1; m_g = s;
          end
        end
      end
`ifdef ST_ARB_WATCHDOG_EN
      else if (!in_valid[m_g]) begin
        m_cnt++;
        if (m_cnt == TO) begin
          m_pkt = 0; m_last = m_g; m_err = 1; m_cnt = 0;
        end
      end
`endif
    end
  endtask

  task automatic tick();
    drive();
    @(negedge clk);
    compare();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_log();
    log_cyc.delete(); log_ch.delete(); log_d.delete(); log_sop.delete(); log_eop.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      src_q[i].delete();
      hold[i] = 0;
      prob[i] = 100;
    end
    tick();
    tick();
    reset = 1'b0;
    clear_log();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pushed;
    int len;
    for (int i = 0; i < NI; i++) begin hold[i] = 0; prob[i] = 100; end
    @(posedge clk);
    #1;

    // Two sources start together after reset: source 0 wins, one bubble, then source 2
    do_reset();
    out_ready = 1'b1;
    src_q[0].push_back(bt(0, 1, 8'hA0)); src_q[0].push_back(bt(0, 0, 8'hA1)); src_q[0].push_back(bt(1, 0, 8'hA2));
    src_q[2].push_back(bt(0, 1, 8'hC0)); src_q[2].push_back(bt(0, 0, 8'hC1)); src_q[2].push_back(bt(1, 0, 8'hC2));
    for (int t = 0; t < 12; t++) tick();
    check("s1_count", log_d.size(), 6);
    if (log_d.size() == 6) begin
      logic [7:0] ed [6];
      ed = '{8'hA0, 8'hA1, 8'hA2, 8'hC0, 8'hC1, 8'hC2};
      for (int k = 0; k < 6; k++) begin
        check("s1_data", 32'(log_d[k]), 32'(ed[k]));
        check("s1_chan", 32'(log_ch[k]), (k < 3) ? 0 : 2);
        check("s1_sop", 32'(log_sop[k]), (k % 3 == 0) ? 1 : 0);
        check("s1_eop", 32'(log_eop[k]), (k % 3 == 2) ? 1 : 0);
      end
      check("s1_bubble", log_cyc[3] - log_cyc[2], 2);
      check("s1_back2back", log_cyc[1] - log_cyc[0], 1);
    end

    // All sources streaming single-beat packets: strict rotation, beat every other cycle
    do_reset();
    for (int i = 0; i < NI; i++)
      for (int j = 0; j < 4; j++) src_q[i].push_back(bt(1, 1, 8'(16 * i + j)));
    for (int t = 0; t < 40; t++) tick();
    check("s2_count", log_ch.size(), 16);
    if (log_ch.size() >= 8) begin
      for (int k = 0; k < 8; k++) check("s2_chan", 32'(log_ch[k]), k % NI);
      for (int k = 1; k < 8; k++) check("s2_gap", log_cyc[k] - log_cyc[k-1], 2);
    end

    // Downstream backpressure for 5 cycles in the middle of a source 1 packet
    do_reset();
    for (int j = 0; j < 4; j++) src_q[1].push_back(bt(j == 3, j == 0, 8'(8'h50 + j)));
    for (int t = 0; t < 3; t++) tick();
    out_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      check("s3_stall_rdy", 32'(in_ready[1]), 0);
    end
    out_ready = 1'b1;
    for (int t = 0; t < 8; t++) tick();
    check("s3_count", log_d.size(), 4);
    for (int k = 0; k < log_d.size() && k < 4; k++) begin
      check("s3_data", 32'(log_d[k]), 32'h50 + k);
      check("s3_chan", 32'(log_ch[k]), 1);
    end

    // Reset on the second beat of a 4-beat packet, then source 0 must win first
    do_reset();
    for (int j = 0; j < 4; j++) src_q[1].push_back(bt(j == 3, j == 0, 8'(8'h60 + j)));
    for (int t = 0; t < 10 && src_q[1].size() != 3; t++) tick();
    check("s4_first_beat", src_q[1].size(), 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    src_q[1].delete();
    check("s4_rst_valid", 32'(out_valid), 0);
    check("s4_rst_grant", 32'(grant), 0);
    check("s4_rst_ready", 32'(in_ready), 0);
    check("s4_rst_data", 32'(out_data), 0);
    clear_log();
    src_q[2].push_back(bt(1, 1, 8'h22));
    src_q[0].push_back(bt(1, 1, 8'h02));
    for (int t = 0; t < 10; t++) tick();
    check("s4_count", log_ch.size(), 2);
    if (log_ch.size() == 2) begin
      check("s4_first_chan", 32'(log_ch[0]), 0);
      check("s4_second_chan", 32'(log_ch[1]), 2);
    end

    // Source 3 sends SOP then goes silent; source 0 waits behind it
    do_reset();
    src_q[3].push_back(bt(0, 1, 8'h30));
    src_q[3].push_back(bt(1, 0, 8'h31));
    for (int t = 0; t < 10 && src_q[3].size() != 1; t++) tick();
    check("s5_sop_taken", src_q[3].size(), 1);
    hold[3] = 1;
    src_q[0].push_back(bt(1, 1, 8'h0A));
    for (int t = 0; t < 30; t++) tick();
`ifdef ST_ARB_WATCHDOG_EN
    check("s5_err", 32'(timeout_err), 1);
    check("s5_grant", 32'(grant), 0);
    check("s5_count", log_d.size(), 2);
    if (log_d.size() == 2) begin
      check("s5_next_chan", 32'(log_ch[1]), 0);
      check("s5_next_data", 32'(log_d[1]), 32'h0A);
    end
`else
    check("s5_err", 32'(timeout_err), 0);
    check("s5_grant", 32'(grant), 32'b1000);
    check("s5_count", log_d.size(), 1);
`endif

    // Randomized traffic: random packets, valid gaps and backpressure
    do_reset();
    pushed = 0;
    for (int i = 0; i < NI; i++) prob[i] = $urandom_range(100, 50);
    for (int t = 0; t < 800; t++) begin
      for (int i = 0; i < NI; i++) begin
        if (src_q[i].size() < 3 && $urandom_range(3) == 0) begin
          len = $urandom_range(4, 1);
          for (int j = 0; j < len; j++) src_q[i].push_back(bt(j == len - 1, j == 0, 8'($urandom)));
          pushed += len;
        end
      end
      out_ready = ($urandom_range(99) < 75);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < NI; i++) prob[i] = 100;
    for (int t = 0; t < 120; t++) tick();
    check("rand_beats_out", log_d.size(), pushed);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
